// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - memory-side req/ack bus between load_store_unit and the data memory port
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // Driven by the LSU
    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    // Driven by the memory
    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with lane steering; optional bus timeout under LSU_BUS_TIMEOUT_EN
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_error,
    output logic [31:0] rsp_rdata,
    load_store_unit_if.master mem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_error;

    logic        accept;
    logic        req_bad;
    logic        in_bus;
    logic        bus_ack;
    logic        tmo_expire;

    logic [3:0]  lane_be;
    logic [31:0] lane_mask;
    logic [31:0] lane_wdata;
    logic [31:0] rd_shift;
    logic [31:0] load_ext;

    assign in_bus  = (state == S_BUS);
    assign bus_ack = in_bus && mem.mem_ack;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt;

    // Expiry fires on the last allowed BUS cycle; an ack in that same cycle still wins
    assign tmo_expire = in_bus && !mem.mem_ack && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Count BUS cycles that pass without an ack; cleared while idle so each access starts fresh
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == S_IDLE) begin
            tmo_cnt <= '0;
        end else if (in_bus && !mem.mem_ack) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end
`else
    logic unused_timeout_cfg;

    assign tmo_expire         = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES >= 32'd1);
`endif

    // Decode the incoming request: misalignment and illegal width encodings
    always_comb begin
        req_bad = 1'b0;
        case (req_funct3[1:0])
            2'b01:   if (req_addr[0]) req_bad = 1'b1;
            2'b10:   if (req_addr[1:0] != 2'b00) req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
        if (req_write) begin
            if (req_funct3 >= 3'b011) req_bad = 1'b1;
        end else begin
            if ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)) req_bad = 1'b1;
        end
    end

    // Byte enables and lane-shifted store data from the registered request
    always_comb begin
        case (r_funct3[1:0])
            2'b01:   lane_be = 4'b0011 << r_addr[1:0];
            2'b10:   lane_be = 4'b1111;
            default: lane_be = 4'b0001 << r_addr[1:0];
        endcase
        lane_mask  = {{8{lane_be[3]}}, {8{lane_be[2]}}, {8{lane_be[1]}}, {8{lane_be[0]}}};
        lane_wdata = (r_wdata << {r_addr[1:0], 3'b000}) & lane_mask;
    end

    // Pull the addressed byte/half down to bit 0 and extend it
    always_comb begin
        rd_shift = mem.mem_rdata >> {r_addr[1:0], 3'b000};
        case (r_funct3)
            3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_ext = {24'd0, rd_shift[7:0]};
            3'b101:  load_ext = {16'd0, rd_shift[15:0]};
            default: load_ext = rd_shift;
        endcase
    end

    // Bus outputs are forced low outside BUS so idle/reset values are clean
    assign mem.mem_req   = in_bus;
    assign mem.mem_we    = in_bus && r_write;
    assign mem.mem_addr  = in_bus ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem.mem_be    = in_bus ? lane_be : 4'd0;
    assign mem.mem_wdata = in_bus ? lane_wdata : 32'd0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_error  = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = req_bad ? S_RESP : S_BUS;
                end
            end
            S_BUS: begin
                if (mem.mem_ack || tmo_expire) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid  = 1'b1;
                rsp_error  = r_error;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Capture the request on accept; update load data only on a completed load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write   <= 1'b0;
            r_funct3  <= 3'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_error   <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            if (accept) begin
                r_write  <= req_write;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_error  <= req_bad;
            end
            if (bus_ack && !r_write) begin
                rsp_rdata <= load_ext;
            end
            if (tmo_expire) begin
                r_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_error;
    logic [31:0] rsp_rdata;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_error  (rsp_error),
        .rsp_rdata  (rsp_rdata),
        .mem        (bus)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
        string       name;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    rsp_t        rsp_q[$];
    bus_t        bus_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        ignore_bus = 1'b0;
    logic [31:0] model_rdata = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expected responses on rsp_valid and checks bus contents while mem_req is high
    always @(negedge clk) begin
        rsp_t e;
        if (!reset) begin
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = rsp_q.pop_front();
                    chk({e.name, "_err"},   32'(rsp_error), 32'(e.err));
                    chk({e.name, "_lat"},   32'(cyc - e.acc), 32'(e.lat));
                    chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
                end
            end
            if (bus.mem_req && !ignore_bus) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", 32'(bus.mem_req), 32'd0);
                end else begin
                    chk("bus_we",    32'(bus.mem_we), 32'(bus_q[0].we));
                    chk("bus_addr",  bus.mem_addr,    bus_q[0].addr);
                    chk("bus_be",    32'(bus.mem_be), 32'(bus_q[0].be));
                    chk("bus_wdata", bus.mem_wdata,   bus_q[0].wdata);
                end
            end
        end
    end

    // One access: waits<0 means memory never acks (timeout path)
    task automatic access(input string name, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int waits, input logic dec_err,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_load, input int lat, input logic hold);
        rsp_t r;
        bus_t b;
        @(negedge clk);
        req_valid     = 1'b1;
        req_write     = wr;
        req_funct3    = f3;
        req_addr      = addr;
        req_wdata     = wdata;
        bus.mem_rdata = rdata;
        if (!dec_err) begin
            b.we    = wr;
            b.addr  = {addr[31:2], 2'b00};
            b.be    = exp_be;
            b.wdata = exp_wdata;
            bus_q.push_back(b);
        end
        chk({name, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        if (!dec_err && !wr && waits >= 0) model_rdata = exp_load;
        r.err   = dec_err || (waits < 0);
        r.rdata = model_rdata;
        r.lat   = lat;
        r.acc   = cyc - 1;
        r.name  = name;
        rsp_q.push_back(r);
        if (!dec_err) begin
            if (waits >= 0) begin
                for (int i = 0; i < waits; i++) begin
                    chk({name, "_req_wait"}, 32'(bus.mem_req), 32'd1);
                    if (hold) chk({name, "_ready_busy"}, 32'(req_ready), 32'd0);
                    @(posedge clk); #1;
                end
                chk({name, "_req_ack"}, 32'(bus.mem_req), 32'd1);
                bus.mem_ack = 1'b1;
                @(posedge clk); #1;
                bus.mem_ack = 1'b0;
            end else begin
                for (int i = 0; i < TMO; i++) begin
                    chk({name, "_req_tmo"}, 32'(bus.mem_req), 32'd1);
                    @(posedge clk); #1;
                end
            end
            void'(bus_q.pop_front());
        end
        chk({name, "_req_low"}, 32'(bus.mem_req), 32'd0);
        if (hold) chk({name, "_ready_resp"}, 32'(req_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_write     = 1'b0;
        req_funct3    = 3'd0;
        req_addr      = 32'd0;
        req_wdata     = 32'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",     32'(req_ready),      32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid),      32'd0);
        chk("rst_rsp_error", 32'(rsp_error),      32'd0);
        chk("rst_rdata",     rsp_rdata,           32'd0);
        chk("rst_mem_req",   32'(bus.mem_req),    32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),     32'd0);
        chk("rst_mem_addr",  bus.mem_addr,        32'd0);
        chk("rst_mem_be",    32'(bus.mem_be),     32'd0);
        chk("rst_mem_wdata", bus.mem_wdata,       32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        //     name     wr    f3      addr          wdata         rdata         w  err   be       exp_wdata     exp_load      lat hold
        access("lb",    1'b0, 3'b000, 32'h103,      32'h0,        32'h80FF1234, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80, 2, 1'b0);
        access("lbu",   1'b0, 3'b100, 32'h103,      32'h0,        32'h80FF1234, 0, 1'b0, 4'b1000, 32'h0,        32'h00000080, 2, 1'b0);
        access("sh",    1'b1, 3'b001, 32'h202,      32'h0000ABCD, 32'h0,        0, 1'b0, 4'b1100, 32'hABCD0000, 32'h0,        2, 1'b0);
        access("lh",    1'b0, 3'b001, 32'h102,      32'h0,        32'h80FF1234, 0, 1'b0, 4'b1100, 32'h0,        32'hFFFF80FF, 2, 1'b0);
        access("lhu",   1'b0, 3'b101, 32'h100,      32'h0,        32'h80FF1234, 0, 1'b0, 4'b0011, 32'h0,        32'h00001234, 2, 1'b0);
        access("sb",    1'b1, 3'b000, 32'h201,      32'h123456A5, 32'h0,        0, 1'b0, 4'b0010, 32'h0000A500, 32'h0,        2, 1'b0);
        access("sw_w1", 1'b1, 3'b010, 32'h300,      32'hDEADBEEF, 32'h0,        1, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0,        3, 1'b0);
        access("lb_pos",1'b0, 3'b000, 32'h3,        32'h0,        32'h7F000000, 0, 1'b0, 4'b1000, 32'h0,        32'h0000007F, 2, 1'b0);
        access("lw_mis",1'b0, 3'b010, 32'h106,      32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        1, 1'b0);
        access("sb_f3", 1'b1, 3'b011, 32'h200,      32'h11,       32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        1, 1'b0);
        access("lh_mis",1'b0, 3'b001, 32'h101,      32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        1, 1'b0);
        access("ld_110",1'b0, 3'b110, 32'h100,      32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        1, 1'b0);
        access("st_100",1'b1, 3'b100, 32'h100,      32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        1, 1'b0);
        access("lw_w3", 1'b0, 3'b010, 32'h10,       32'h0,        32'hCAFEF00D, 3, 1'b0, 4'b1111, 32'h0,        32'hCAFEF00D, 5, 1'b1);
        access("lb_nxt",1'b0, 3'b000, 32'h11,       32'h0,        32'hCAFEF00D, 0, 1'b0, 4'b0010, 32'h0,        32'hFFFFFFF0, 2, 1'b0);

        // Reset during BUS, then a stray ack while idle
        @(negedge clk);
        ignore_bus = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_req_bus", 32'(bus.mem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_rdata = 32'd0;
        chk("mid_req_low", 32'(bus.mem_req), 32'd0);
        chk("mid_ready",   32'(req_ready),   32'd1);
        chk("mid_rdata",   rsp_rdata,        32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h55555555;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("late_ack_rsp",   32'(rsp_valid),   32'd0);
        chk("late_ack_req",   32'(bus.mem_req), 32'd0);
        chk("late_ack_rdata", rsp_rdata,        32'd0);
        repeat (2) @(posedge clk);
        #1;
        ignore_bus = 1'b0;

        access("lbu_rs",1'b0, 3'b100, 32'h0,        32'h0,        32'h000000AA, 0, 1'b0, 4'b0001, 32'h0,        32'h000000AA, 2, 1'b0);

`ifdef LSU_BUS_TIMEOUT_EN
        access("lw_tmo",1'b0, 3'b010, 32'h20,       32'h0,        32'h0,       -1, 1'b0, 4'b1111, 32'h0,        32'h0,        5, 1'b0);
        access("lw_ack4",1'b0,3'b010, 32'h24,       32'h0,        32'h11223344, 3, 1'b0, 4'b1111, 32'h0,        32'h11223344, 5, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
